// File: rtl/guessing_game_n.sv
// guessing_game_n: LFSR-seeded number guessing game with synchronised submit key, hi/lo feedback, try budget and saturating win count
module guessing_game_n #(
  parameter int          WIDTH     = 3,
  parameter int          MAX_TRIES = 4,
  parameter int          SCORE_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [WIDTH-1:0]                 guess,
  input  logic                             submit_n,
  input  logic                             new_game,
  output logic                             hi,
  output logic                             lo,
  output logic                             correct,
  output logic                             lose,
  output logic                             playing,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [SCORE_W-1:0]               wins,
  output logic [WIDTH-1:0]                 secret_o
);
  localparam int TW = $clog2(MAX_TRIES+1);
  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;
  state_t      state;
  logic [15:0] lfsr;
  logic        s1, s2, s3;
  logic        press;
  // falling edge of the synchronised key: one event per press however long it is held
  assign press = ~s2 & s3;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      {s3, s2, s1} <= 3'b111;
      hi         <= 1'b0;
      lo         <= 1'b0;
      correct    <= 1'b0;
      lose       <= 1'b0;
      playing    <= 1'b0;
      tries_left <= '0;
      wins       <= '0;
      secret_o   <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
      {s3, s2, s1} <= {s2, s1, submit_n};
      if (new_game) begin
        state      <= PLAY;
        secret_o   <= lfsr[WIDTH-1:0];
        tries_left <= TW'(MAX_TRIES);
        hi         <= 1'b0;
        lo         <= 1'b0;
        correct    <= 1'b0;
        lose       <= 1'b0;
        playing    <= 1'b1;
      end else if (press && state == PLAY) begin
        if (guess == secret_o) begin
          state   <= WIN;
          hi      <= 1'b0;
          lo      <= 1'b0;
          correct <= 1'b1;
          playing <= 1'b0;
          wins    <= (wins == '1) ? wins : wins + SCORE_W'(1);
        end else begin
          hi         <= guess > secret_o;
          lo         <= guess < secret_o;
          tries_left <= tries_left - TW'(1);
          if (tries_left == TW'(1)) begin
            state   <= LOSE;
            lose    <= 1'b1;
            playing <= 1'b0;
          end
        end
      end
    end
endmodule

// File: tb/tb_guessing_game_n.sv
// tb_guessing_game_n: directed self-checking bench for guessing_game_n (SCORE_W=2 to reach saturation)
module tb_guessing_game_n;
  logic       clk = 1'b0, reset_n = 1'b0, submit_n = 1'b1, new_game = 1'b0;
  logic [2:0] guess = '0;
  logic       hi, lo, correct, lose, playing;
  logic [2:0] tries_left, secret_o;
  logic [1:0] wins;
  int         total = 0, bad = 0;
  logic [15:0] m_lfsr;
  logic [2:0]  exp_secret;
  logic [9:0]  exp_st;
  wire  [9:0]  st = {hi, lo, correct, lose, playing, tries_left, wins};

  always #5 clk = ~clk;

  // reference LFSR: x^16+x^15+x^13+x^4, shifts every edge
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};

  guessing_game_n #(.WIDTH(3), .MAX_TRIES(4), .SCORE_W(2), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .guess(guess), .submit_n(submit_n), .new_game(new_game),
    .hi(hi), .lo(lo), .correct(correct), .lose(lose), .playing(playing),
    .tries_left(tries_left), .wins(wins), .secret_o(secret_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_game(input int target, input logic [1:0] w);
    int i = 0;
    while (target >= 0 && m_lfsr[2:0] != target[2:0] && i < 64) begin
      tick(1);
      i++;
    end
    total++;
    if (i >= 64) begin
      bad++;
      $display("FAIL lfsr_target got=%0d want=%0d", m_lfsr[2:0], target);
    end
    exp_secret = m_lfsr[2:0];
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    total++;
    if ({st, secret_o} !== {5'b00001, 3'd4, w, exp_secret}) begin
      bad++;
      $display("FAIL start_game got=%b/%0d want=%b/%0d", st, secret_o, {5'b00001, 3'd4, w}, exp_secret);
    end
  endtask

  task automatic press(input logic [2:0] g, input int hold);
    guess = g;
    submit_n = 1'b0;
    tick(hold);
    submit_n = 1'b1;
    tick(4);
  endtask

  task automatic pulse(input logic [2:0] g);
    @(negedge clk);
    guess = g;
    submit_n = 1'b0;
    @(negedge clk);
    submit_n = 1'b1;
    tick(4);
  endtask

  task automatic test_reset;
    #12 reset_n = 1'b1;
    start_game(-1, 2'd0);
    press(exp_secret ^ 3'd1, 2);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    total++;
    if ({st, secret_o} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset got=%b/%0d want=0", st, secret_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    new_game = 1'b1;
    tick(1);
    total++;
    if ({st, secret_o} !== {5'b00001, 3'd4, 2'd0, 3'd1}) begin
      bad++;
      $display("FAIL seed_secret got=%b/%0d want=%b/1", st, secret_o, {5'b00001, 3'd4, 2'd0});
    end
    tick(1);
    new_game = 1'b0;
    total++;
    if (secret_o !== 3'd3) begin
      bad++;
      $display("FAIL second_secret got=%0d want=3", secret_o);
    end
  endtask

  task automatic test_correct;
    start_game(5, 2'd0);
    guess = 3'd5;
    submit_n = 1'b0;
    tick(2);
    total++;
    if (st !== {5'b00001, 3'd4, 2'd0}) begin
      bad++;
      $display("FAIL latency_early got=%b want=%b", st, {5'b00001, 3'd4, 2'd0});
    end
    tick(1);
    total++;
    if (st !== {5'b00100, 3'd4, 2'd1}) begin
      bad++;
      $display("FAIL correct got=%b want=%b", st, {5'b00100, 3'd4, 2'd1});
    end
    tick(8);
    submit_n = 1'b1;
    tick(4);
    total++;
    if (st !== {5'b00100, 3'd4, 2'd1}) begin
      bad++;
      $display("FAIL hold_key got=%b want=%b", st, {5'b00100, 3'd4, 2'd1});
    end
  endtask

  task automatic test_hilo;
    start_game(3, 2'd1);
    press(3'd6, 3);
    total++;
    if (st !== {5'b10001, 3'd3, 2'd1}) begin
      bad++;
      $display("FAIL hi got=%b want=%b", st, {5'b10001, 3'd3, 2'd1});
    end
    guess = 3'd3;
    tick(5);
    total++;
    if (st !== {5'b10001, 3'd3, 2'd1}) begin
      bad++;
      $display("FAIL guess_idle got=%b want=%b", st, {5'b10001, 3'd3, 2'd1});
    end
    press(3'd1, 1);
    total++;
    if (st !== {5'b01001, 3'd2, 2'd1}) begin
      bad++;
      $display("FAIL lo got=%b want=%b", st, {5'b01001, 3'd2, 2'd1});
    end
    press(3'd3, 2);
    total++;
    if (st !== {5'b00100, 3'd2, 2'd2}) begin
      bad++;
      $display("FAIL hilo_win got=%b want=%b", st, {5'b00100, 3'd2, 2'd2});
    end
  endtask

  task automatic test_lose;
    start_game(6, 2'd2);
    for (int i = 0; i < 5; i++) begin
      press(3'd7, 2);
      exp_st = (i >= 3) ? {5'b10010, 3'd0, 2'd2} : {5'b10001, 3'(3 - i), 2'd2};
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL lose_press%0d got=%b want=%b", i, st, exp_st);
      end
    end
  endtask

  task automatic test_priority;
    start_game(2, 2'd2);
    press(3'd0, 2);
    press(3'd0, 2);
    total++;
    if (st !== {5'b01001, 3'd2, 2'd2}) begin
      bad++;
      $display("FAIL pre_priority got=%b want=%b", st, {5'b01001, 3'd2, 2'd2});
    end
    guess = 3'd2;
    submit_n = 1'b0;
    tick(2);
    exp_secret = m_lfsr[2:0];
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    total++;
    if ({st, secret_o} !== {5'b00001, 3'd4, 2'd2, exp_secret}) begin
      bad++;
      $display("FAIL priority got=%b/%0d want=%b/%0d", st, secret_o, {5'b00001, 3'd4, 2'd2}, exp_secret);
    end
    submit_n = 1'b1;
    tick(4);
    total++;
    if (st !== {5'b00001, 3'd4, 2'd2}) begin
      bad++;
      $display("FAIL press_dropped got=%b want=%b", st, {5'b00001, 3'd4, 2'd2});
    end
    repeat (4) press(exp_secret ^ 3'd1, 1);
    total++;
    if ({lose, playing, tries_left} !== {2'b10, 3'd0}) begin
      bad++;
      $display("FAIL reach_lose got=%b want=%b", {lose, playing, tries_left}, {2'b10, 3'd0});
    end
    start_game(-1, 2'd2);
  endtask

  task automatic test_saturation;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    for (int g = 0; g < 5; g++) begin
      start_game(-1, (g == 0) ? 2'd0 : ((g > 3) ? 2'd3 : 2'(g)));
      pulse(exp_secret ^ 3'd2);
      total++;
      if (tries_left !== 3'd3) begin
        bad++;
        $display("FAIL pulse_once%0d got=%0d want=3", g, tries_left);
      end
      pulse(exp_secret);
      exp_st = {5'b00100, 3'd3, (g >= 2) ? 2'd3 : 2'(g + 1)};
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL saturate%0d got=%b want=%b", g, st, exp_st);
      end
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_hilo;
    test_lose;
    test_priority;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/guessing_game_n.md
Name: guessing_game_n

Overview:
- Parametrised number-guessing game controller for the DE1-SoC lab flow; generalises the fixed 3-bit switch-compare game.
- Generates a pseudo-random secret from a free-running LFSR and accepts guesses on a raw push-button.
- Gives higher/lower feedback and enforces a try budget.
- Keeps a saturating win counter.
- Sits between board I/O (SW, KEY) and LEDR/HEX display logic.

Parameters:
- WIDTH, 3, bit width of secret and guess (1..16).
- MAX_TRIES, 4, guesses allowed per game (>=1).
- SCORE_W, 4, width of win counter.
- LFSR_SEED, 16'hACE1, reset value of 16-bit LFSR; must be nonzero.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- guess, in, WIDTH, player guess (SW), sampled at the submit event.
- submit_n, in, 1, raw active-low key; asynchronous to clk.
- new_game, in, 1, single-cycle pulse that starts or restarts a game.
- hi, out, 1, last guess was greater than the secret.
- lo, out, 1, last guess was less than the secret.
- correct, out, 1, high in WIN.
- lose, out, 1, high in LOSE.
- playing, out, 1, high in PLAY.
- tries_left, out, $clog2(MAX_TRIES+1), remaining guesses.
- wins, out, SCORE_W, games won, saturating.
- secret_o, out, WIDTH, current secret; verification and debug only.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, LFSR=LFSR_SEED, sync flops=1.
  - hi=lo=correct=lose=playing=0, tries_left=0, wins=0, secret=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,15,13,4; advances every clk edge in every state.
  - Never reaches zero, given a nonzero seed.
- Submit path:
  - submit_n passes through a 2-flop synchroniser (s1, s2), then a delay flop s3.
  - Press event = s2==0 && s3==1; exactly one event per press, regardless of hold time.
  - Latency: if submit_n is low at edge k, the state and outputs update at edge k+2. All outputs are registered.
- States: IDLE, PLAY, WIN, LOSE.
- new_game in any state:
  - secret <= LFSR[WIDTH-1:0] (value before that edge's shift).
  - tries_left <= MAX_TRIES; hi=lo=0; next state PLAY.
  - In PLAY this abandons the current game with no win/lose recorded.
- Press event in PLAY (no new_game in the same cycle), compare guess to secret, unsigned:
  - Equal: next state WIN; hi=lo=0; wins<=wins+1, saturating at 2^SCORE_W-1; tries_left unchanged.
  - guess>secret: hi=1, lo=0; tries_left-1.
  - guess<secret: lo=1, hi=0; tries_left-1.
  - Wrong guess with tries_left==1: tries_left=0, hi/lo still updated, next state LOSE.
- Press events in IDLE, WIN or LOSE are ignored; no output changes.
- new_game and a press event in the same cycle: new_game takes priority and the press is dropped.
- correct=1 only in WIN; lose=1 only in LOSE; playing=1 only in PLAY. Outputs hold until the next transition.
- guess is sampled only on the press-event cycle; changes at other times are ignored.
- Reset mid-game: immediate return to IDLE; wins cleared.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> all outputs 0 immediately. Release, then new_game -> playing=1, tries_left=4, secret_o = LFSR[2:0] at that edge.
- Correct guess: secret_o=5, guess=5, submit_n low 10 cycles -> correct=1 exactly 2 edges after first low sample, wins=1. Holding the key causes no further change.
- Hi/lo: secret_o=3. Guess 6 -> hi=1, tries_left=3. Guess 1 -> lo=1, hi=0, tries_left=2. Guess 3 -> correct=1, tries_left=2.
- Lose: secret_o≠0, four presses with guess=secret_o^1 -> tries_left 3,2,1,0; lose=1 after 4th; 5th press has no effect; wins unchanged.
- Priority/restart: new_game in the same cycle as a press event while tries_left=2 -> tries_left=4, hi=lo=0, press dropped. new_game from LOSE -> PLAY.
- Saturation: SCORE_W=2, win 5 games -> wins 1,2,3,3,3. Glitch-free single press per key cycle, checked with 1-cycle-wide low pulses straddling edges.
